// File: rtl/sobel_window_ctrl_pkg.sv
// Shared constants for the Sobel 3x3 window controller: FSM encoding,
// default frame geometry and the column/row counter width.
package sobel_window_ctrl_pkg;

  localparam int unsigned CNT_W = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] PIC_WIDTH_DEF  = 11'd250;
  localparam logic [CNT_W-1:0] PIC_HEIGHT_DEF = 11'd250;

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel storage; the read port returns the old content so a
// same-cycle write at the same address behaves read-before-write.
module sobel_line_buf
  import sobel_window_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 32'(PIC_WIDTH_DEF),
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_c = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-order pixel intake that produces the three vertical taps of a 3x3
// Sobel window using two line buffers, with frame start/abort sequencing.
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] PIC_WIDTH  = PIC_WIDTH_DEF,
  parameter logic [CNT_W-1:0] PIC_HEIGHT = PIC_HEIGHT_DEF,
  parameter int unsigned      WIDTH      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned LB_AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             valid_out_q, valid_out_d;
  logic [WIDTH-1:0] dout1_q, dout1_d;
  logic [WIDTH-1:0] dout2_q, dout2_d;
  logic [WIDTH-1:0] dout3_q, dout3_d;

  logic             accept_c;
  logic             last_col_c;
  logic [LB_AW-1:0] lb_addr_c;
  logic [WIDTH-1:0] lb0_rdata_c;
  logic [WIDTH-1:0] lb1_rdata_c;

  // abort outranks an accept in the same cycle
  assign accept_c   = in_valid && in_ready_q && !abort;
  assign last_col_c = (col_q == PIC_WIDTH - 11'd1);
  assign lb_addr_c  = LB_AW'(col_q);

  sobel_line_buf #(
    .DEPTH (32'(PIC_WIDTH)),
    .WIDTH (WIDTH),
    .AW    (LB_AW)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (accept_c),
    .addr_i  (lb_addr_c),
    .wdata_i (in_data),
    .rdata_c (lb0_rdata_c)
  );

  sobel_line_buf #(
    .DEPTH (32'(PIC_WIDTH)),
    .WIDTH (WIDTH),
    .AW    (LB_AW)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (accept_c),
    .addr_i  (lb_addr_c),
    .wdata_i (lb0_rdata_c),
    .rdata_c (lb1_rdata_c)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    dout1_d      = dout1_q;
    dout2_d      = dout2_q;
    dout3_d      = dout3_q;

    if (abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FILL;
            col_d   = '0;
            row_d   = '0;
          end
        end
        ST_FILL: begin
          if (accept_c && last_col_c && (row_q == 11'd1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (accept_c && last_col_c && (row_q == PIC_HEIGHT - 11'd1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (accept_c) begin
        if (last_col_c) begin
          col_d = '0;
          row_d = row_q + 11'd1;
        end else begin
          col_d = col_q + 11'd1;
        end
        dout3_d     = in_data;
        dout2_d     = lb0_rdata_c;
        dout1_d     = lb1_rdata_c;
        valid_out_d = (row_q >= 11'd2);
      end
    end

    in_ready_d = (state_d == ST_FILL) || (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      valid_out_q  <= 1'b0;
      dout1_q      <= '0;
      dout2_q      <= '0;
      dout3_q      <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      valid_out_q  <= valid_out_d;
      dout1_q      <= dout1_d;
      dout2_q      <= dout2_d;
      dout3_q      <= dout3_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign valid_out  = valid_out_q;
  assign dout1      = dout1_q;
  assign dout2      = dout2_q;
  assign dout3      = dout3_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 4x3 frame: expected tap
// triples are queued as pixels are accepted and popped on each valid_out.
module tb_sobel_window_ctrl;

  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         valid_out;
  logic [W-1:0] dout1, dout2, dout3;
  logic         busy;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int vo_cnt = 0;

  logic [3*W-1:0] exp_q [$];
  logic [W-1:0]   frm [12];

  sobel_window_ctrl #(
    .PIC_WIDTH  (11'd4),
    .PIC_HEIGHT (11'd3),
    .WIDTH      (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .valid_out  (valid_out),
    .dout1      (dout1),
    .dout2      (dout2),
    .dout3      (dout3),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every valid_out must match the oldest queued tap triple
  always @(negedge clk) begin
    logic [3*W-1:0] e;
    if (rst_n === 1'b1 && valid_out === 1'b1) begin
      vo_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid_out: taps %0h,%0h,%0h with nothing expected", dout1, dout2, dout3);
      end else begin
        e = exp_q.pop_front();
        if ({dout1, dout2, dout3} !== e) begin
          errors++;
          $display("FAIL taps: got %0h,%0h,%0h required %0h,%0h,%0h",
                   dout1, dout2, dout3, e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start: in_ready=%b busy=%b required 1 1", in_ready, busy);
    end
  endtask

  task automatic send_pix(input int k, input logic [W-1:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_pix%0d: in_ready stayed 0, required 1", k);
    end else begin
      frm[k] = d;
      if (k >= 8) exp_q.push_back({frm[k-8], frm[k-4], d});
    end
  endtask

  task automatic run_frame(input logic [W-1:0] base, input bit gaps, input int start_at);
    int vo0;
    do_start();
    vo0 = vo_cnt;
    for (int k = 0; k < 12; k++) begin
      if (k == start_at) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_pix(k, base + W'(k));
      if (gaps && k < 11) begin
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 1'b0 || dout3 !== base + W'(k) ||
            (k >= 4 && dout2 !== base + W'(k - 4)) ||
            (k >= 8 && dout1 !== base + W'(k - 8))) begin
          errors++;
          $display("FAIL gap_hold%0d: valid_out=%b taps %0h,%0h,%0h", k, valid_out, dout1, dout2, dout3);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_state: frame_done=%b in_ready=%b busy=%b required 0 0 1", frame_done, in_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse: frame_done=%b busy=%b valid_out=%b required 1 0 0", frame_done, busy, valid_out);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: frame_done=%b required 0", frame_done);
    end
    checks++;
    if (vo_cnt - vo0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tap_count: got %0d valid_out (%0d pending) required 4 (0)", vo_cnt - vo0, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({in_ready, valid_out, busy, frame_done} !== 4'b0 || {dout1, dout2, dout3} !== '0) begin
      errors++;
      $display("FAIL reset: ready/valid/busy/done=%b%b%b%b taps %0h,%0h,%0h required all 0",
               in_ready, valid_out, busy, frame_done, dout1, dout2, dout3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_pixels();
    in_valid = 1'b1;
    in_data  = 24'hABCDEF;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0 || dout3 !== '0) begin
      errors++;
      $display("FAIL idle_pixels: in_ready=%b busy=%b valid_out=%b dout3=%0h required 0 0 0 0",
               in_ready, busy, valid_out, dout3);
    end
  endtask

  task automatic test_full_frame();
    run_frame(24'd1, 1'b0, -1);
  endtask

  task automatic test_toggle();
    run_frame(24'd1, 1'b1, -1);
  endtask

  task automatic test_abort();
    int vo0;
    do_start();
    for (int k = 0; k < 6; k++) send_pix(k, 24'(k + 1));
    vo0 = vo_cnt;
    in_valid = 1'b1;
    in_data  = 24'd7;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL abort: in_ready=%b busy=%b valid_out=%b required 0 0 0", in_ready, busy, valid_out);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (frame_done !== 1'b0 || valid_out !== 1'b0 || vo_cnt != vo0) begin
        errors++;
        $display("FAIL abort_quiet%0d: frame_done=%b valid_out=%b", i, frame_done, valid_out);
      end
    end
    run_frame(24'd1, 1'b0, -1);
  endtask

  task automatic test_start_in_run();
    run_frame(24'd1, 1'b0, 9);
  endtask

  task automatic test_back_to_back();
    run_frame(24'h100, 1'b0, -1);
    run_frame(24'h200, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int k = 0; k < 10; k++) send_pix(k, 24'(k + 1));
    in_valid = 1'b1;
    in_data  = 24'd11;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, valid_out, busy, frame_done} !== 4'b0 || {dout1, dout2, dout3} !== '0) begin
      errors++;
      $display("FAIL reset_mid: ready/valid/busy/done=%b%b%b%b taps %0h,%0h,%0h required all 0",
               in_ready, valid_out, busy, frame_done, dout1, dout2, dout3);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending: %0d taps pending required 0", exp_q.size());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle%0d: in_ready=%b busy=%b valid_out=%b required 0 0 0",
                 i, in_ready, busy, valid_out);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_pixels();
    test_full_frame();
    test_toggle();
    test_abort();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
